// File: rtl/ripple_count_sequencer.sv
// rtl/ripple_count_sequencer.sv - clk-domain sequencer issuing counted pulses to a ripple counter and checking its value
module ripple_count_sequencer #(
  parameter int WIDTH      = 4,
  parameter int PULSE_CYC  = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_t,
  output logic             cnt_clk,
  output logic             cnt_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] count_out
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, PULSE_HI, PULSE_LO, SETTLE, CHECK, DONE
  } state_t;

  localparam int MAXC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] S_LAST = TW'(SETTLE_CYC - 1);

  state_t           state;
  logic [TW-1:0]    tmr;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] shadow;
  logic             stop_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmr       <= '0;
      tgt       <= '0;
      shadow    <= '0;
      stop_pend <= 1'b0;
      cnt_t     <= 1'b0;
      cnt_clk   <= 1'b0;
      cnt_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      count_out <= '0;
    end else begin
      // Stop only latches here; it is acted on at the next CHECK so pulses are never cut short.
      if (busy && stop)
        stop_pend <= 1'b1;

      case (state)
        IDLE, DONE: begin
          cnt_rst <= 1'b0;
          if (start) begin
            tgt       <= target;
            err       <= 1'b0;
            done      <= 1'b0;
            stop_pend <= 1'b0;
            shadow    <= '0;
            cnt_rst   <= 1'b1;
            busy      <= 1'b1;
            state     <= CLEAR;
          end
        end

        CLEAR: begin
          cnt_rst <= 1'b0;
          tmr     <= '0;
          if (tgt == '0) begin
            count_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt_t   <= 1'b1;
            cnt_clk <= 1'b1;
            state   <= PULSE_HI;
          end
        end

        PULSE_HI: begin
          if (tmr == P_LAST) begin
            tmr     <= '0;
            cnt_clk <= 1'b0;
            shadow  <= shadow + 1'b1;
            state   <= PULSE_LO;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        PULSE_LO: begin
          if (tmr == P_LAST) begin
            tmr   <= '0;
            state <= SETTLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        SETTLE: begin
          if (tmr == S_LAST) begin
            tmr   <= '0;
            state <= CHECK;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        CHECK: begin
          count_out <= cnt_q;
          if (cnt_q != shadow || shadow == tgt || stop_pend || stop) begin
            if (cnt_q != shadow)
              err <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt_t   <= 1'b0;
            cnt_clk <= 1'b0;
            state   <= DONE;
          end else begin
            tmr     <= '0;
            cnt_clk <= 1'b1;
            state   <= PULSE_HI;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_count_sequencer.sv
// tb/tb_ripple_count_sequencer.sv - table-driven bench with a behavioural ripple counter model
module tb_ripple_count_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] target;
  logic [3:0] cnt_q;
  logic       cnt_t;
  logic       cnt_clk;
  logic       cnt_rst;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] count_out;

  logic [3:0] ctr;
  logic       fault;
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         falls  = 0;
  int         rises  = 0;

  always #5 clk = ~clk;

  ripple_count_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .target(target),
    .cnt_q(cnt_q), .cnt_t(cnt_t), .cnt_clk(cnt_clk), .cnt_rst(cnt_rst),
    .busy(busy), .done(done), .err(err), .count_out(count_out)
  );

  // Counter advances on the falling edge of cnt_clk when enabled; fault forces bit 1 low.
  always @(negedge cnt_clk or posedge cnt_rst)
    if (cnt_rst) ctr <= 4'd0;
    else if (cnt_t) ctr <= ctr + 4'd1;

  assign cnt_q = fault ? (ctr & 4'b1101) : ctr;

  always @(negedge cnt_clk) falls++;
  always @(posedge cnt_clk) rises++;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int target;
    int stop_at;   // -1 none, 0 together with start, k during pulse k HI
    int poke;      // cycle at which a second start (target 2) is attempted, 0 none
    bit fault;
    int exp_cnt;
    int exp_err;
    int exp_cyc;
    int exp_ctr;
    int exp_falls;
  } vec_t;

  vec_t vecs[8];

  task automatic run(input vec_t v, input int idx);
    int cyc = 0;
    bit stopped = 1'b0;
    @(negedge clk);
    target = v.target[3:0];
    fault  = v.fault;
    start  = 1'b1;
    stop   = (v.stop_at == 0);
    falls  = 0;
    rises  = 0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk($sformatf("v%0d busy_after_start", idx), busy, 1);
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      stop  = 1'b0;
      if (v.poke != 0 && cyc == v.poke) begin
        target = 4'd2;
        start  = 1'b1;
      end
      if (v.stop_at > 0 && !stopped && rises == v.stop_at) begin
        stop    = 1'b1;
        stopped = 1'b1;
      end
      if (done) break;
    end
    start = 1'b0;
    stop  = 1'b0;
    chk($sformatf("v%0d cycles_to_done", idx), cyc, v.exp_cyc);
    chk($sformatf("v%0d count_out", idx), count_out, v.exp_cnt);
    chk($sformatf("v%0d err", idx), err, v.exp_err);
    chk($sformatf("v%0d busy_at_done", idx), busy, 0);
    chk($sformatf("v%0d cnt_clk_falls", idx), falls, v.exp_falls);
    chk($sformatf("v%0d counter_value", idx), ctr, v.exp_ctr);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d done_held", idx), done, 1);
  endtask

  initial begin
    vecs[0] = '{target: 5,  stop_at: -1, poke: 0, fault: 0, exp_cnt: 5,  exp_err: 0, exp_cyc: 26, exp_ctr: 5,  exp_falls: 5};
    vecs[1] = '{target: 0,  stop_at: -1, poke: 0, fault: 0, exp_cnt: 0,  exp_err: 0, exp_cyc: 1,  exp_ctr: 0,  exp_falls: 0};
    vecs[2] = '{target: 15, stop_at: -1, poke: 0, fault: 0, exp_cnt: 15, exp_err: 0, exp_cyc: 76, exp_ctr: 15, exp_falls: 15};
    vecs[3] = '{target: 3,  stop_at: -1, poke: 0, fault: 0, exp_cnt: 3,  exp_err: 0, exp_cyc: 16, exp_ctr: 3,  exp_falls: 3};
    vecs[4] = '{target: 9,  stop_at: 4,  poke: 0, fault: 0, exp_cnt: 4,  exp_err: 0, exp_cyc: 21, exp_ctr: 4,  exp_falls: 4};
    vecs[5] = '{target: 6,  stop_at: -1, poke: 0, fault: 1, exp_cnt: 0,  exp_err: 1, exp_cyc: 11, exp_ctr: 2,  exp_falls: 2};
    vecs[6] = '{target: 1,  stop_at: 0,  poke: 0, fault: 0, exp_cnt: 1,  exp_err: 0, exp_cyc: 6,  exp_ctr: 1,  exp_falls: 1};
    vecs[7] = '{target: 4,  stop_at: -1, poke: 7, fault: 0, exp_cnt: 4,  exp_err: 0, exp_cyc: 21, exp_ctr: 4,  exp_falls: 4};

    rst = 1'b1; start = 1'b0; stop = 1'b0; target = 4'd0; fault = 1'b0;
    #1;
    chk("reset cnt_rst", cnt_rst, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset cnt_t", cnt_t, 0);
    chk("reset cnt_clk", cnt_clk, 0);
    chk("reset count_out", count_out, 0);
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle cnt_rst_released", cnt_rst, 0);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle stop_ignored_busy", busy, 0);

    for (int i = 0; i < 8; i++) run(vecs[i], i);

    // Reset in the middle of a run clears the counter asynchronously.
    @(negedge clk);
    target = 4'd9; start = 1'b1; fault = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrun counter_nonzero", (ctr != 4'd0), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrun cnt_rst", cnt_rst, 1);
    chk("midrun busy", busy, 0);
    chk("midrun done", done, 0);
    chk("midrun counter_cleared", ctr, 0);
    @(negedge clk);
    rst = 1'b0;

    run('{target: 2, stop_at: -1, poke: 0, fault: 0, exp_cnt: 2, exp_err: 0, exp_cyc: 11, exp_ctr: 2, exp_falls: 2}, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
